// File: rtl/muldiv_execute_unit.sv
// Iterative multiply/divide execute stage: shift-add MUL and restoring DIV at one bit
// per edge, single-edge LUI and divide-by-zero, with the architectural flag register.
module muldiv_execute_unit #(
  parameter int l     = 16,
  parameter int imm_l = 7,
  parameter int p     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [p:0]       ALUOpcode,
  input  logic             UseImmediate,
  input  logic             LoadUpperImmediate,
  input  logic             UpdateFlags,
  input  logic [l-1:0]     RegA,
  input  logic [l-1:0]     RegB,
  input  logic [imm_l-1:0] Immediate,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [l-1:0]     Result,
  output logic [l-1:0]     HighResult,
  output logic             ZeroFlag,
  output logic             OverflowFlag,
  output logic             DivZeroFlag
);

  localparam int CNT_W = (l > 2) ? $clog2(l) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, nextState;
  logic [CNT_W-1:0] iterCnt;
  logic [l-1:0]     accHi, accLo, operandQ;
  logic             isMulQ, updFlagsQ;

  logic [l-1:0]     operandB, luiValue;
  logic             isMul, divByZero, lastIter;
  logic [2*l-1:0]   stepFirst, stepBusy;

  // One shift-add step: {hi,lo} holds partial product above the remaining multiplier bits.
  function automatic logic [2*l-1:0] mulStep(input logic [l-1:0] hi, input logic [l-1:0] lo,
                                             input logic [l-1:0] mcand);
    logic [l:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(l+1){1'b0}});
    return {sum, lo[l-1:1]};
  endfunction

  // One restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
  function automatic logic [2*l-1:0] divStep(input logic [l-1:0] hi, input logic [l-1:0] lo,
                                             input logic [l-1:0] dvsr);
    logic [l:0] trial;
    trial = {hi, lo[l-1]} - {1'b0, dvsr};
    if (!trial[l]) return {trial[l-1:0], lo[l-2:0], 1'b1};
    else           return {hi[l-2:0], lo[l-1], lo[l-2:0], 1'b0};
  endfunction

  assign isMul     = (ALUOpcode == (p+1)'(1));
  assign operandB  = UseImmediate ? {{(l-imm_l){1'b0}}, Immediate} : RegB;
  assign luiValue  = {Immediate, {(l-imm_l){1'b0}}};
  assign divByZero = !isMul && (operandB == '0);
  assign lastIter  = (iterCnt == CNT_W'(l-1));

  // The accept edge already performs the first iteration on the incoming operands.
  assign stepFirst = isMul  ? mulStep('0, operandB, RegA) : divStep('0, RegA, operandB);
  assign stepBusy  = isMulQ ? mulStep(accHi, accLo, operandQ) : divStep(accHi, accLo, operandQ);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (InValid) nextState = (LoadUpperImmediate || divByZero) ? DONE : BUSY;
      BUSY: if (lastIter) nextState = DONE;
      DONE: if (OutReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    InReady  = (state == IDLE);
    OutValid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iterCnt      <= '0;
      accHi        <= '0;
      accLo        <= '0;
      operandQ     <= '0;
      isMulQ       <= 1'b0;
      updFlagsQ    <= 1'b0;
      Result       <= '0;
      HighResult   <= '0;
      ZeroFlag     <= 1'b0;
      OverflowFlag <= 1'b0;
      DivZeroFlag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InValid) begin
          isMulQ    <= isMul;
          updFlagsQ <= UpdateFlags;
          if (LoadUpperImmediate) begin
            Result     <= luiValue;
            HighResult <= '0;
            if (UpdateFlags) begin
              ZeroFlag     <= (luiValue == '0);
              OverflowFlag <= 1'b0;
              DivZeroFlag  <= 1'b0;
            end
          end else if (divByZero) begin
            Result     <= '1;
            HighResult <= RegA;
            if (UpdateFlags) begin
              ZeroFlag     <= 1'b0;
              OverflowFlag <= 1'b0;
              DivZeroFlag  <= 1'b1;
            end
          end else begin
            iterCnt  <= CNT_W'(1);
            accHi    <= stepFirst[2*l-1:l];
            accLo    <= stepFirst[l-1:0];
            operandQ <= isMul ? RegA : operandB;
          end
        end
        BUSY: begin
          iterCnt <= iterCnt + CNT_W'(1);
          accHi   <= stepBusy[2*l-1:l];
          accLo   <= stepBusy[l-1:0];
          if (lastIter) begin
            iterCnt    <= '0;
            Result     <= stepBusy[l-1:0];
            HighResult <= stepBusy[2*l-1:l];
            if (updFlagsQ) begin
              ZeroFlag     <= (stepBusy[l-1:0] == '0);
              OverflowFlag <= isMulQ && (stepBusy[2*l-1:l] != '0);
              DivZeroFlag  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_execute_unit.sv
// Directed bench for muldiv_execute_unit: hand-computed MUL/DIV/LUI vectors, flag
// updates, handshake stalls and mid-operation reset.
module tb_muldiv_execute_unit;

  logic        clk;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [0:0]  ALUOpcode;
  logic        UseImmediate;
  logic        LoadUpperImmediate;
  logic        UpdateFlags;
  logic [15:0] RegA;
  logic [15:0] RegB;
  logic [6:0]  Immediate;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] Result;
  logic [15:0] HighResult;
  logic        ZeroFlag;
  logic        OverflowFlag;
  logic        DivZeroFlag;

  int nVec = 0;
  int nErr = 0;
  int lat;
  logic seen;

  muldiv_execute_unit #(.l(16), .imm_l(7), .p(0)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .ALUOpcode(ALUOpcode), .UseImmediate(UseImmediate),
    .LoadUpperImmediate(LoadUpperImmediate), .UpdateFlags(UpdateFlags),
    .RegA(RegA), .RegB(RegB), .Immediate(Immediate),
    .OutValid(OutValid), .OutReady(OutReady),
    .Result(Result), .HighResult(HighResult),
    .ZeroFlag(ZeroFlag), .OverflowFlag(OverflowFlag), .DivZeroFlag(DivZeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [0:0] op, input logic useImm, input logic lui,
                       input logic upd, input logic [15:0] a, input logic [15:0] b,
                       input logic [6:0] imm);
    ALUOpcode = op; UseImmediate = useImm; LoadUpperImmediate = lui;
    UpdateFlags = upd; RegA = a; RegB = b; Immediate = imm;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  // Latency counts the accept edge as 1; bounded so a stuck unit still reaches the summary.
  task automatic waitValid(output int n);
    n = 1;
    while (!OutValid && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake(input string tag);
    OutReady = 1'b1;
    tick();
    OutReady = 1'b0;
    check({tag, "_vld_drop"}, {31'd0, OutValid}, 32'd0);
    check({tag, "_inrdy"},    {31'd0, InReady},  32'd1);
  endtask

  initial begin
    reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    ALUOpcode = 1'b0; UseImmediate = 1'b0; LoadUpperImmediate = 1'b0; UpdateFlags = 1'b0;
    RegA = '0; RegB = '0; Immediate = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_inrdy",  {31'd0, InReady},  32'd1);
    check("rst_outvld", {31'd0, OutValid}, 32'd0);
    check("rst_res",    {16'd0, Result},     32'd0);
    check("rst_hi",     {16'd0, HighResult}, 32'd0);
    check("rst_flags",  {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'd0);

    // MUL 300*200 = 60000
    issue(1'b1, 1'b0, 1'b0, 1'b1, 16'd300, 16'd200, 7'd0);
    check("mul_busy_inrdy", {31'd0, InReady}, 32'd0);
    waitValid(lat);
    check("mul_lat",   lat, 32'd16);
    check("mul_res",   {16'd0, Result},     32'h0000EA60);
    check("mul_hi",    {16'd0, HighResult}, 32'h00000000);
    check("mul_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b000);
    handshake("mul");

    // DIV 1000/7 = 142 r 6, operands scrambled after accept
    issue(1'b0, 1'b0, 1'b0, 1'b1, 16'd1000, 16'd7, 7'd0);
    RegB = 16'd0; RegA = 16'd0;
    waitValid(lat);
    check("div_lat",   lat, 32'd16);
    check("div_res",   {16'd0, Result},     32'h0000008E);
    check("div_hi",    {16'd0, HighResult}, 32'h00000006);
    check("div_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b000);
    handshake("div");

    // DIV by zero
    issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'd0, 7'd0);
    waitValid(lat);
    check("dz_lat",   lat, 32'd1);
    check("dz_res",   {16'd0, Result},     32'h0000FFFF);
    check("dz_hi",    {16'd0, HighResult}, 32'h00001234);
    check("dz_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b001);
    handshake("dz");

    // MUL immediate 0x1000*0x20 = 0x20000
    issue(1'b1, 1'b1, 1'b0, 1'b1, 16'h1000, 16'h0003, 7'h20);
    waitValid(lat);
    check("muli_lat",   lat, 32'd16);
    check("muli_res",   {16'd0, Result},     32'h00000000);
    check("muli_hi",    {16'd0, HighResult}, 32'h00000002);
    check("muli_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b110);
    handshake("muli");

    // LUI 0x55 with MUL opcode present, flags not updated
    issue(1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0009, 7'h55);
    waitValid(lat);
    check("lui_lat",   lat, 32'd1);
    check("lui_res",   {16'd0, Result},     32'h0000AA00);
    check("lui_hi",    {16'd0, HighResult}, 32'h00000000);
    check("lui_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b110);
    handshake("lui");

    // MUL 0x123*0x456 = 0x4EDC2, stalled in DONE with a competing request
    issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h0123, 16'h0456, 7'd0);
    waitValid(lat);
    check("stall_lat", lat, 32'd16);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 7'h7F);
    InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_vld",   {31'd0, OutValid}, 32'd1);
      check("stall_inrdy", {31'd0, InReady},  32'd0);
      check("stall_res",   {16'd0, Result},     32'h0000EDC2);
      check("stall_hi",    {16'd0, HighResult}, 32'h00000004);
      tick();
    end
    InValid = 1'b0;
    check("stall_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b110);
    handshake("stall");

    // Reset after 8 iterations of a MUL
    issue(1'b1, 1'b0, 1'b0, 1'b1, 16'd5, 16'd5, 7'd0);
    for (int i = 0; i < 7; i++) tick();
    check("mid_busy", {31'd0, OutValid}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_vld",   {31'd0, OutValid}, 32'd0);
    check("mid_inrdy", {31'd0, InReady},  32'd1);
    check("mid_flags", {29'd0, ZeroFlag, OverflowFlag, DivZeroFlag}, 32'b000);
    check("mid_res",   {16'd0, Result}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (OutValid) seen = 1'b1;
      tick();
    end
    check("mid_noresult", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/muldiv_execute_unit.md
Name: muldiv_execute_unit

Overview:
- Execute stage that consumes the decoded control word (ALUOpcode, UseImmediate, LoadUpperImmediate, UpdateFlags) and performs the operation on register/immediate operands.
- MUL and DIV run iteratively: shift-add and restoring division, one bit per cycle. LUI completes in one cycle.
- Input side uses a valid/ready handshake from decode; output side uses a valid/ready handshake to writeback. Owns the architectural flag register.

Parameters:
- l, 16, datapath width in bits.
- imm_l, 7, immediate field width; zero-extended to l bits.
- p, 0, ALUOpcode msb index (ALUOpcode is p+1 bits).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- InValid  in  1  decode presents an operation.
- InReady  out  1  unit can accept; equals (state==IDLE).
- ALUOpcode  in  p+1  1 = MUL, 0 = DIV.
- UseImmediate  in  1  operand B = zero-extended Immediate instead of RegB.
- LoadUpperImmediate  in  1  LUI; takes priority over ALUOpcode.
- UpdateFlags  in  1  write flags on completion.
- RegA  in  l  operand A (multiplicand / dividend).
- RegB  in  l  operand B (multiplier / divisor).
- Immediate  in  imm_l  immediate field.
- OutValid  out  1  Result/HighResult valid.
- OutReady  in  1  writeback accepts result.
- Result  out  l  MUL low product, DIV quotient, or LUI value.
- HighResult  out  l  MUL high product, DIV remainder, LUI 0.
- ZeroFlag  out  1  registered flag.
- OverflowFlag  out  1  registered flag.
- DivZeroFlag  out  1  registered flag.

Behaviour:
- Reset (synchronous, active-high; clk is the only clock): state=IDLE, InReady=1 in the following cycle. OutValid, Result, HighResult, all flags and the iteration counter are 0. Reset mid-operation discards the in-flight operation with no output and no flag write.
- Accept: on an edge where InValid && InReady. Opcode, operands, OperandB = UseImmediate ? {0, Immediate} : RegB, and UpdateFlags are latched. Input changes after accept are ignored.
- States and transitions:
  - IDLE -> LUI path: Result = Immediate << (l-imm_l), i.e. 0xAA00 for 0x55 at l=16; HighResult = 0. Next state DONE; OutValid is high 1 cycle after the accept edge.
  - IDLE -> DIV-by-zero (OperandB==0): Result = all ones, HighResult = dividend, DivZero condition set. Next state DONE; latency 1.
  - IDLE -> MUL or DIV otherwise: state runs for exactly l iteration edges, then DONE. OutValid is high l cycles after the accept edge (16 at default).
  - MUL: unsigned, 2l-bit product; low half to Result, high half to HighResult.
  - DIV: unsigned restoring division; quotient to Result, remainder to HighResult.
  - DONE: OutValid=1 and outputs held stable. On an edge with OutReady=1, go to IDLE and drop OutValid. OutReady is ignored outside DONE.
- Flags: written on the edge entering DONE, and only if the latched UpdateFlags=1; otherwise they hold their previous value.
  - Zero = (Result==0).
  - Overflow = MUL && HighResult!=0; 0 for DIV and LUI.
  - DivZero = DIV with divisor 0.
- InReady=0 in every state except IDLE, so there is at most one operation in flight. The earliest next accept is the cycle after the OutReady handshake.
- Result and HighResult retain their last values in IDLE.

Test Plan:
- MUL RegA=300, RegB=200, UpdateFlags=1 -> OutValid exactly 16 cycles after accept; Result=0xEA60, HighResult=0x0000, Z=0, V=0, D=0.
- MULi RegA=0x1000, Immediate=0x20 -> Result=0x0000, HighResult=0x0002, Z=1, V=1.
- DIV RegA=1000, RegB=7 -> Result=0x008E, HighResult=0x0006 after 16 cycles; RegB changed to 0 after accept -> no effect.
- DIV RegA=0x1234, RegB=0 -> OutValid 1 cycle after accept; Result=0xFFFF, HighResult=0x1234, D=1, Z=0.
- LUI Immediate=0x55, UpdateFlags=0, with flags previously Z=1 V=1 -> Result=0xAA00, HighResult=0; flags remain Z=1, V=1; latency 1.
- MUL with OutReady held low 5 cycles in DONE -> outputs stable, InReady=0, InValid ignored. Separately, assert reset at iteration 8 of a MUL -> next cycle OutValid=0, flags=0, InReady=1, and no result is ever presented.
